dio_pulse_stamper: RTL and testbench

Timestamps edges on one DIO input channel against the White Rabbit time base (tm_seconds/tm_cycles) and queues the stamps in a small FIFO. It sits directly upstream of wrsw_dio's register/Wishbone block, which pops stamps through a show-ahead read interface. One instance per DIO channel; runs entirely in the reference clock domain.

---
 rtl/dio_pulse_stamper.sv | 143 ++++++++++++++
 tb/tb_dio_pulse_stamper.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dio_pulse_stamper.sv
// dio_pulse_stamper: stamps DIO input edges against WR time and queues them in a show-ahead FIFO.
// Define DIO_STAMP_FALLING_EN to also stamp falling edges (ts_edge_o=0); otherwise ts_edge_o is tied 1.
module dio_pulse_stamper #(
    parameter int g_fifo_depth     = 16,
    parameter int g_sync_delay     = 3,
    parameter int g_cycles_per_sec = 125000000
) (
    input  logic                          clk_ref_i,
    input  logic                          rst_n_i,
    input  logic                          pulse_i,
    input  logic                          tm_time_valid_i,
    input  logic [39:0]                   tm_seconds_i,
    input  logic [27:0]                   tm_cycles_i,
    output logic                          ts_valid_o,
    input  logic                          ts_rd_i,
    output logic [39:0]                   ts_seconds_o,
    output logic [27:0]                   ts_cycles_o,
    output logic                          ts_edge_o,
    output logic [$clog2(g_fifo_depth):0] ts_count_o,
    output logic                          overflow_o,
    output logic [15:0]                   drop_cnt_o,
    input  logic                          clr_ovf_i
);
    localparam int AW = $clog2(g_fifo_depth);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(g_fifo_depth);
    localparam logic [27:0] DLY = 28'(g_sync_delay);
    localparam logic [27:0] WRAP_ADJ = 28'(g_cycles_per_sec - g_sync_delay);
`ifdef DIO_STAMP_FALLING_EN
    localparam int EW = 69;
`else
    localparam int EW = 68;
`endif

    logic [2:0]    sync_q;
    logic          rise;
    logic          det;
    logic          det_q;
    logic [39:0]   tm_sec_q;
    logic [27:0]   tm_cyc_q;
    logic [39:0]   comp_sec;
    logic [27:0]   comp_cyc;
    logic [EW-1:0] stamp_d;
    logic [EW-1:0] stamp_q;
    logic          stamp_vld_q;
    logic [EW-1:0] mem [g_fifo_depth];
    logic [EW-1:0] head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;

    assign rise = sync_q[1] & ~sync_q[2];

`ifdef DIO_STAMP_FALLING_EN
    logic rise_q;
    assign det = rise | (~sync_q[1] & sync_q[2]);
    always_ff @(posedge clk_ref_i or negedge rst_n_i)
        if (!rst_n_i)
            rise_q <= 1'b0;
        else
            rise_q <= rise;
    assign stamp_d = {rise_q, comp_sec, comp_cyc};
`else
    assign det = rise;
    assign stamp_d = {comp_sec, comp_cyc};
`endif

    // sync_q[1:0] is the synchronizer, sync_q[2] the edge-detect delay flop
    always_ff @(posedge clk_ref_i or negedge rst_n_i)
        if (!rst_n_i) begin
            sync_q   <= '0;
            det_q    <= 1'b0;
            tm_sec_q <= '0;
            tm_cyc_q <= '0;
        end else begin
            sync_q   <= {sync_q[1:0], pulse_i};
            det_q    <= det & tm_time_valid_i;
            tm_sec_q <= tm_seconds_i;
            tm_cyc_q <= tm_cycles_i;
        end

    // back the stamp up to the pin edge, borrowing a second when cycles underflow
    always_comb begin
        comp_sec = (tm_cyc_q >= DLY) ? tm_sec_q : tm_sec_q - 40'd1;
        comp_cyc = (tm_cyc_q >= DLY) ? tm_cyc_q - DLY : tm_cyc_q + WRAP_ADJ;
    end

    always_ff @(posedge clk_ref_i or negedge rst_n_i)
        if (!rst_n_i) begin
            stamp_vld_q <= 1'b0;
            stamp_q     <= '0;
        end else begin
            stamp_vld_q <= det_q;
            stamp_q     <= stamp_d;
        end

    assign full = count_q == FULL_CNT;
    assign pop  = ts_rd_i & (count_q != '0);
    assign push = stamp_vld_q & (~full | pop);
    assign drop = stamp_vld_q & full & ~pop;

    always_ff @(posedge clk_ref_i)
        if (push)
            mem[wr_ptr] <= stamp_q;

    always_ff @(posedge clk_ref_i or negedge rst_n_i)
        if (!rst_n_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            wr_ptr  <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr  <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end

    // a clear coinciding with a drop still records that drop
    always_ff @(posedge clk_ref_i or negedge rst_n_i)
        if (!rst_n_i) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (clr_ovf_i) begin
            overflow_o <= drop;
            drop_cnt_o <= {15'd0, drop};
        end else if (drop) begin
            overflow_o <= 1'b1;
            drop_cnt_o <= (drop_cnt_o == 16'hFFFF) ? drop_cnt_o : drop_cnt_o + 16'd1;
        end

    assign head         = mem[rd_ptr];
    assign ts_valid_o   = count_q != '0;
    assign ts_count_o   = count_q;
    assign ts_seconds_o = ts_valid_o ? head[67:28] : 40'd0;
    assign ts_cycles_o  = ts_valid_o ? head[27:0] : 28'd0;
`ifdef DIO_STAMP_FALLING_EN
    assign ts_edge_o    = ts_valid_o & head[68];
`else
    assign ts_edge_o    = 1'b1;
`endif
endmodule

// File: tb/tb_dio_pulse_stamper.sv
// tb_dio_pulse_stamper: directed checks of stamping, compensation, FIFO and overflow handling.
module tb_dio_pulse_stamper;
    logic        clk = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        pulse_i = 1'b0;
    logic        tm_time_valid_i = 1'b0;
    logic [39:0] tm_seconds_i = '0;
    logic [27:0] tm_cycles_i = '0;
    logic        ts_valid_o;
    logic        ts_rd_i = 1'b0;
    logic [39:0] ts_seconds_o;
    logic [27:0] ts_cycles_o;
    logic        ts_edge_o;
    logic [4:0]  ts_count_o;
    logic        overflow_o;
    logic [15:0] drop_cnt_o;
    logic        clr_ovf_i = 1'b0;
    int          passed = 0;
    int          total = 0;

    dio_pulse_stamper dut (
        .clk_ref_i(clk), .rst_n_i(rst_n_i), .pulse_i(pulse_i),
        .tm_time_valid_i(tm_time_valid_i), .tm_seconds_i(tm_seconds_i), .tm_cycles_i(tm_cycles_i),
        .ts_valid_o(ts_valid_o), .ts_rd_i(ts_rd_i), .ts_seconds_o(ts_seconds_o),
        .ts_cycles_o(ts_cycles_o), .ts_edge_o(ts_edge_o), .ts_count_o(ts_count_o),
        .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o), .clr_ovf_i(clr_ovf_i)
    );

    always #5 clk = ~clk;

`ifdef DIO_STAMP_FALLING_EN
    localparam logic IDLE_EDGE = 1'b0;
    localparam int   FALL_STAMPS = 2;
`else
    localparam logic IDLE_EDGE = 1'b1;
    localparam int   FALL_STAMPS = 1;
`endif

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // leaves the bench one cycle before the stamp is pushed
    task automatic rise_edge(input logic [39:0] s, input logic [27:0] c);
        tm_seconds_i = s;
        tm_cycles_i = c;
        tm_time_valid_i = 1'b1;
        pulse_i = 1'b1;
        tick(4);
    endtask

    task automatic fall_quiet();
        tm_time_valid_i = 1'b0;
        pulse_i = 1'b0;
        tick(4);
        tm_time_valid_i = 1'b1;
    endtask

    task automatic pop_one();
        ts_rd_i = 1'b1;
        tick(1);
        ts_rd_i = 1'b0;
    endtask

    task automatic test_reset();
        tick(3);
        total++; if (ts_valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", ts_valid_o); else passed++;
        total++; if (ts_seconds_o !== 40'd0 || ts_cycles_o !== 28'd0) $display("FAIL reset_stamp got %0d/%0d want 0/0", ts_seconds_o, ts_cycles_o); else passed++;
        total++; if (ts_edge_o !== IDLE_EDGE) $display("FAIL reset_edge got %b want %b", ts_edge_o, IDLE_EDGE); else passed++;
        total++; if (ts_count_o !== 5'd0) $display("FAIL reset_count got %0d want 0", ts_count_o); else passed++;
        total++; if (overflow_o !== 1'b0 || drop_cnt_o !== 16'd0) $display("FAIL reset_ovf got %b/%0d want 0/0", overflow_o, drop_cnt_o); else passed++;
        rst_n_i = 1'b1;
        tm_time_valid_i = 1'b1;
        tick(2);
    endtask

    task automatic test_latency();
        tm_seconds_i = 40'd5;
        tm_cycles_i = 28'd1000;
        pulse_i = 1'b1;
        tick(4);
        total++; if (ts_valid_o !== 1'b0) $display("FAIL latency_early got valid %b want 0", ts_valid_o); else passed++;
        tick(1);
        total++; if (ts_valid_o !== 1'b1) $display("FAIL latency_n4 got valid %b want 1", ts_valid_o); else passed++;
        total++; if (ts_seconds_o !== 40'd5 || ts_cycles_o !== 28'd997) $display("FAIL latency_stamp got %0d/%0d want 5/997", ts_seconds_o, ts_cycles_o); else passed++;
        total++; if (ts_edge_o !== 1'b1) $display("FAIL latency_edge got %b want 1", ts_edge_o); else passed++;
        total++; if (ts_count_o !== 5'd1) $display("FAIL latency_count got %0d want 1", ts_count_o); else passed++;
        fall_quiet();
        pop_one();
        total++; if (ts_valid_o !== 1'b0 || ts_count_o !== 5'd0) $display("FAIL pop_to_empty got %b/%0d want 0/0", ts_valid_o, ts_count_o); else passed++;
        pop_one();
        total++; if (ts_count_o !== 5'd0) $display("FAIL pop_empty got count %0d want 0", ts_count_o); else passed++;
    endtask

    task automatic test_wrap();
        rise_edge(40'd7, 28'd1);
        fall_quiet();
        total++; if (ts_seconds_o !== 40'd6 || ts_cycles_o !== 28'd124999998) $display("FAIL wrap_borrow got %0d/%0d want 6/124999998", ts_seconds_o, ts_cycles_o); else passed++;
        pop_one();
        rise_edge(40'd0, 28'd0);
        fall_quiet();
        total++; if (ts_seconds_o !== 40'hFFFFFFFFFF || ts_cycles_o !== 28'd124999997) $display("FAIL wrap_zero got %h/%0d want ffffffffff/124999997", ts_seconds_o, ts_cycles_o); else passed++;
        pop_one();
    endtask

    task automatic test_invalid_time();
        tm_time_valid_i = 1'b0;
        pulse_i = 1'b1;
        tick(6);
        pulse_i = 1'b0;
        tick(6);
        tm_time_valid_i = 1'b1;
        total++; if (ts_count_o !== 5'd0 || ts_valid_o !== 1'b0) $display("FAIL invalid_time got %0d/%b want 0/0", ts_count_o, ts_valid_o); else passed++;
        total++; if (drop_cnt_o !== 16'd0 || overflow_o !== 1'b0) $display("FAIL invalid_drop got %0d/%b want 0/0", drop_cnt_o, overflow_o); else passed++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 17; i++) begin
            rise_edge(40'd3, 28'(100 + i));
            fall_quiet();
        end
        total++; if (ts_count_o !== 5'd16) $display("FAIL ovf_count got %0d want 16", ts_count_o); else passed++;
        total++; if (overflow_o !== 1'b1 || drop_cnt_o !== 16'd1) $display("FAIL ovf_flag got %b/%0d want 1/1", overflow_o, drop_cnt_o); else passed++;
        rise_edge(40'd3, 28'd150);
        clr_ovf_i = 1'b1;
        tick(1);
        clr_ovf_i = 1'b0;
        total++; if (overflow_o !== 1'b1 || drop_cnt_o !== 16'd1) $display("FAIL clr_vs_drop got %b/%0d want 1/1", overflow_o, drop_cnt_o); else passed++;
        fall_quiet();
        clr_ovf_i = 1'b1;
        tick(1);
        clr_ovf_i = 1'b0;
        total++; if (overflow_o !== 1'b0 || drop_cnt_o !== 16'd0) $display("FAIL ovf_clear got %b/%0d want 0/0", overflow_o, drop_cnt_o); else passed++;
        for (int i = 0; i < 16; i++) begin
            total++; if (ts_seconds_o !== 40'd3 || ts_cycles_o !== 28'(97 + i)) $display("FAIL ovf_order[%0d] got %0d/%0d want 3/%0d", i, ts_seconds_o, ts_cycles_o, 97 + i); else passed++;
            pop_one();
        end
        total++; if (ts_valid_o !== 1'b0 || ts_count_o !== 5'd0) $display("FAIL ovf_drained got %b/%0d want 0/0", ts_valid_o, ts_count_o); else passed++;
    endtask

    task automatic test_full_pop_push();
        for (int i = 0; i < 16; i++) begin
            rise_edge(40'd4, 28'(200 + i));
            fall_quiet();
        end
        total++; if (ts_count_o !== 5'd16) $display("FAIL full_count got %0d want 16", ts_count_o); else passed++;
        rise_edge(40'd4, 28'd300);
        ts_rd_i = 1'b1;
        tick(1);
        ts_rd_i = 1'b0;
        total++; if (ts_count_o !== 5'd16) $display("FAIL popush_count got %0d want 16", ts_count_o); else passed++;
        total++; if (overflow_o !== 1'b0 || drop_cnt_o !== 16'd0) $display("FAIL popush_drop got %b/%0d want 0/0", overflow_o, drop_cnt_o); else passed++;
        fall_quiet();
        for (int i = 0; i < 16; i++) begin
            total++; if (ts_cycles_o !== ((i < 15) ? 28'(198 + i) : 28'd297)) $display("FAIL popush_order[%0d] got %0d want %0d", i, ts_cycles_o, (i < 15) ? 198 + i : 297); else passed++;
            pop_one();
        end
        total++; if (ts_valid_o !== 1'b0) $display("FAIL popush_drained got %b want 0", ts_valid_o); else passed++;
    endtask

    task automatic test_falling();
        rise_edge(40'd9, 28'd500);
        tick(1);
        total++; if (ts_count_o !== 5'd1) $display("FAIL fall_first_count got %0d want 1", ts_count_o); else passed++;
        tick(5);
        pulse_i = 1'b0;
        tm_cycles_i = 28'd510;
        tick(4);
        total++; if (ts_count_o !== 5'd1) $display("FAIL fall_early got count %0d want 1", ts_count_o); else passed++;
        tick(1);
        total++; if (ts_count_o !== 5'(FALL_STAMPS)) $display("FAIL fall_count got %0d want %0d", ts_count_o, FALL_STAMPS); else passed++;
        total++; if (ts_edge_o !== 1'b1 || ts_cycles_o !== 28'd497) $display("FAIL fall_head1 got %b/%0d want 1/497", ts_edge_o, ts_cycles_o); else passed++;
        pop_one();
`ifdef DIO_STAMP_FALLING_EN
        total++; if (ts_edge_o !== 1'b0 || ts_cycles_o !== 28'd507) $display("FAIL fall_head2 got %b/%0d want 0/507", ts_edge_o, ts_cycles_o); else passed++;
        pop_one();
`endif
        total++; if (ts_valid_o !== 1'b0) $display("FAIL fall_drained got %b want 0", ts_valid_o); else passed++;
    endtask

    task automatic test_reset_mid();
        rise_edge(40'd1, 28'd10);
        fall_quiet();
        rise_edge(40'd1, 28'd20);
        fall_quiet();
        pulse_i = 1'b1;
        tick(2);
        pulse_i = 1'b0;
        rst_n_i = 1'b0;
        #1;
        total++; if (ts_valid_o !== 1'b0 || ts_count_o !== 5'd0) $display("FAIL mid_reset_fifo got %b/%0d want 0/0", ts_valid_o, ts_count_o); else passed++;
        total++; if (ts_seconds_o !== 40'd0 || ts_cycles_o !== 28'd0) $display("FAIL mid_reset_stamp got %0d/%0d want 0/0", ts_seconds_o, ts_cycles_o); else passed++;
        tick(2);
        rst_n_i = 1'b1;
        tick(8);
        total++; if (ts_count_o !== 5'd0) $display("FAIL mid_reset_pending got count %0d want 0", ts_count_o); else passed++;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_wrap();
        test_invalid_time();
        test_overflow();
        test_full_pop_push();
        test_falling();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
